// File: rtl/multi_edge_detect.sv
// rtl/multi_edge_detect.sv - multi-channel edge detector with pulse stretch and holdoff
//
// Each channel synchronises its input, qualifies edges by the shared mode,
// emits a PULSE_LEN-cycle pulse and then ignores the channel for a latched
// holdoff period. Edges seen while busy raise a one-cycle missed flag.
//
// Ports:
//   clk      - system clock, all logic on rising edge
//   reset    - synchronous, active-high reset
//   in       - [CHANNELS] channel inputs, asynchronous unless SYNC_STAGES = 0
//   mode     - 00 rising, 01 falling, 10 both, 11 disabled (shared by all channels)
//   holdoff  - [HOLD_WIDTH] holdoff length in cycles, latched per channel at detection
//   out      - [CHANNELS] per-channel detection pulse, registered
//   missed   - [CHANNELS] one-cycle flag: qualifying edge while channel busy
//   any_out  - OR of out, registered alongside out
module multi_edge_detect #(
   parameter int CHANNELS    = 4,
   parameter int SYNC_STAGES = 2,
   parameter int PULSE_LEN   = 1,
   parameter int HOLD_WIDTH  = 5
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [CHANNELS-1:0]   in,
   input  logic [1:0]            mode,
   input  logic [HOLD_WIDTH-1:0] holdoff,
   output logic [CHANNELS-1:0]   out,
   output logic [CHANNELS-1:0]   missed,
   output logic                  any_out
);

   localparam int PW = $clog2(PULSE_LEN + 1);
   localparam int CW = (HOLD_WIDTH > PW) ? HOLD_WIDTH : PW;
   localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_LEN - 1);

   typedef enum logic [1:0] {
      ST_WAIT,
      ST_ASSERT,
      ST_HOLDOFF
   } state_t;

   logic [CHANNELS-1:0] s;
   logic [CHANNELS-1:0] p_q;
   logic [CHANNELS-1:0] qual;
   logic [CHANNELS-1:0] out_d;
   logic [CHANNELS-1:0] missed_d;
   logic                disabled;

   assign disabled = (mode == 2'b11);

   generate
      if (SYNC_STAGES == 0) begin : g_nosync
         assign s = in;
      end else begin : g_sync
         logic [CHANNELS-1:0] sync_q [SYNC_STAGES];
         always_ff @(posedge clk) begin
            if (reset) begin
               for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
            end else begin
               sync_q[0] <= in;
               for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
            end
         end
         assign s = sync_q[SYNC_STAGES-1];
      end
   endgenerate

   // p follows s unconditionally so a level that persists through a busy
   // period never looks like a fresh edge when the channel returns to WAIT.
   always_ff @(posedge clk) begin
      if (reset) p_q <= '0;
      else       p_q <= s;
   end

   always_comb begin
      qual = '0;
      case (mode)
         2'b00:   qual = s & ~p_q;
         2'b01:   qual = ~s & p_q;
         2'b10:   qual = s ^ p_q;
         default: qual = '0;
      endcase
   end

   genvar i;
   generate
      for (i = 0; i < CHANNELS; i++) begin : g_ch
         state_t                state;
         logic [CW-1:0]         cnt;
         logic [HOLD_WIDTH-1:0] h_q;
         logic                  miss_q;
         logic [CW-1:0]         h_last;

         assign h_last = CW'(h_q) - CW'(1);

         // Outputs lag the FSM by one register; disable forces them low at
         // the same edge the FSM is forced back to WAIT.
         assign out_d[i]    = (state == ST_ASSERT) && !disabled;
         assign missed_d[i] = miss_q && !disabled;

         always_ff @(posedge clk) begin
            if (reset) begin
               state  <= ST_WAIT;
               cnt    <= '0;
               h_q    <= '0;
               miss_q <= 1'b0;
            end else begin
               miss_q <= qual[i] && (state != ST_WAIT);
               if (disabled) begin
                  state <= ST_WAIT;
                  cnt   <= '0;
               end else begin
                  case (state)
                     ST_WAIT: begin
                        if (qual[i]) begin
                           state <= ST_ASSERT;
                           cnt   <= '0;
                           h_q   <= holdoff;
                        end
                     end
                     ST_ASSERT: begin
                        if (cnt == PULSE_LAST) begin
                           cnt   <= '0;
                           state <= (h_q == '0) ? ST_WAIT : ST_HOLDOFF;
                        end else begin
                           cnt <= cnt + CW'(1);
                        end
                     end
                     ST_HOLDOFF: begin
                        if (cnt == h_last) begin
                           cnt   <= '0;
                           state <= ST_WAIT;
                        end else begin
                           cnt <= cnt + CW'(1);
                        end
                     end
                     default: begin
                        state <= ST_WAIT;
                        cnt   <= '0;
                     end
                  endcase
               end
            end
         end
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (reset) begin
         out     <= '0;
         missed  <= '0;
         any_out <= 1'b0;
      end else begin
         out     <= out_d;
         missed  <= missed_d;
         any_out <= |out_d;
      end
   end

endmodule

// File: tb/tb_multi_edge_detect.sv
// tb/tb_multi_edge_detect.sv - self-checking bench for multi_edge_detect
module tb_multi_edge_detect;

   logic       clk;
   logic       reset;
   logic [3:0] in_v;
   logic [1:0] mode;
   logic [4:0] holdoff;

   logic [3:0] out_p1, missed_p1, out_p3, missed_p3, out_p4, missed_p4;
   logic       any_p1, any_p3, any_p4;

   multi_edge_detect #(.CHANNELS(4), .SYNC_STAGES(2), .PULSE_LEN(1), .HOLD_WIDTH(5)) u_p1 (
      .clk(clk), .reset(reset), .in(in_v), .mode(mode), .holdoff(holdoff),
      .out(out_p1), .missed(missed_p1), .any_out(any_p1));
   multi_edge_detect #(.CHANNELS(4), .SYNC_STAGES(2), .PULSE_LEN(3), .HOLD_WIDTH(5)) u_p3 (
      .clk(clk), .reset(reset), .in(in_v), .mode(mode), .holdoff(holdoff),
      .out(out_p3), .missed(missed_p3), .any_out(any_p3));
   multi_edge_detect #(.CHANNELS(4), .SYNC_STAGES(2), .PULSE_LEN(4), .HOLD_WIDTH(5)) u_p4 (
      .clk(clk), .reset(reset), .in(in_v), .mode(mode), .holdoff(holdoff),
      .out(out_p4), .missed(missed_p4), .any_out(any_p4));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int nchk = 0;
   int npass = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act === exp) npass++;
      else $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Scoreboard: a countdown model per DUT/channel. rem = busy cycles left
   // (pulse plus holdoff); the channel is pulsing while rem exceeds its holdoff.
   typedef struct {
      logic [3:0] out;
      logic [3:0] missed;
      logic       any;
   } exp_t;

   exp_t sbq[$];
   bit   sb_en;
   int   p_tab[3] = '{1, 3, 4};
   int   rem[3][4];
   int   hl[3][4];
   bit   x1[3][4], x2[3][4], pp[3][4], mp[3][4];
   bit   m_s, m_q, m_dis;
   exp_t m_e, c_e;
   logic [3:0] a_out, a_miss;
   logic       a_any;

   always @(posedge clk) begin
      if (sb_en) begin
         for (int d = 0; d < 3; d++) begin
            m_e.out = '0;
            m_e.missed = '0;
            for (int c = 0; c < 4; c++) begin
               if (reset) begin
                  x1[d][c] = 0; x2[d][c] = 0; pp[d][c] = 0; mp[d][c] = 0;
                  rem[d][c] = 0; hl[d][c] = 0;
               end else begin
                  m_s = x2[d][c];
                  m_dis = (mode == 2'b11);
                  case (mode)
                     2'b00:   m_q = m_s & ~pp[d][c];
                     2'b01:   m_q = ~m_s & pp[d][c];
                     2'b10:   m_q = m_s ^ pp[d][c];
                     default: m_q = 0;
                  endcase
                  m_e.out[c]    = !m_dis && (rem[d][c] > hl[d][c]);
                  m_e.missed[c] = !m_dis && mp[d][c];
                  mp[d][c] = !m_dis && (rem[d][c] > 0) && m_q;
                  if (m_dis) rem[d][c] = 0;
                  else if (rem[d][c] == 0) begin
                     if (m_q) begin
                        rem[d][c] = p_tab[d] + int'(holdoff);
                        hl[d][c]  = int'(holdoff);
                     end
                  end else rem[d][c] = rem[d][c] - 1;
                  pp[d][c] = m_s;
                  x2[d][c] = x1[d][c];
                  x1[d][c] = in_v[c];
               end
            end
            m_e.any = |m_e.out;
            sbq.push_back(m_e);
         end
         #1;
         for (int d = 0; d < 3; d++) begin
            c_e = sbq.pop_front();
            case (d)
               0:       begin a_out = out_p1; a_miss = missed_p1; a_any = any_p1; end
               1:       begin a_out = out_p3; a_miss = missed_p3; a_any = any_p3; end
               default: begin a_out = out_p4; a_miss = missed_p4; a_any = any_p4; end
            endcase
            chk($sformatf("sb_out_p%0d", p_tab[d]), 32'(a_out), 32'(c_e.out));
            chk($sformatf("sb_missed_p%0d", p_tab[d]), 32'(a_miss), 32'(c_e.missed));
            chk($sformatf("sb_any_p%0d", p_tab[d]), 32'(a_any), 32'(c_e.any));
         end
      end
   end

   typedef struct {
      logic [1:0] mode;
      logic [4:0] hold;
      logic [3:0] in;
      logic [3:0] exp_out;
      logic [3:0] exp_miss;
   } vec_t;

   vec_t tab[21];

   task automatic do_reset();
      reset = 1'b1;
      in_v  = '0;
      tick(2);
      reset = 1'b0;
   endtask

   int out_cnt, out_at, miss_cnt, miss_at, rises, any_cnt;
   bit prev;

   initial begin
      // Rising on ch0 (P1, holdoff 20), then falling-only on ch3 with holdoff 0,
      // then disabled. Expected values are for the PULSE_LEN=1 instance.
      tab[0]  = '{2'b00, 5'd20, 4'b0000, 4'b0000, 4'b0000};
      tab[1]  = '{2'b00, 5'd20, 4'b0000, 4'b0000, 4'b0000};
      tab[2]  = '{2'b00, 5'd20, 4'b0001, 4'b0000, 4'b0000};
      tab[3]  = '{2'b00, 5'd20, 4'b0001, 4'b0000, 4'b0000};
      tab[4]  = '{2'b00, 5'd20, 4'b0001, 4'b0000, 4'b0000};
      tab[5]  = '{2'b00, 5'd20, 4'b0001, 4'b0001, 4'b0000};
      tab[6]  = '{2'b00, 5'd20, 4'b0001, 4'b0000, 4'b0000};
      tab[7]  = '{2'b00, 5'd20, 4'b0001, 4'b0000, 4'b0000};
      tab[8]  = '{2'b01, 5'd0,  4'b1001, 4'b0000, 4'b0000};
      tab[9]  = '{2'b01, 5'd0,  4'b0001, 4'b0000, 4'b0000};
      tab[10] = '{2'b01, 5'd0,  4'b1001, 4'b0000, 4'b0000};
      tab[11] = '{2'b01, 5'd0,  4'b0001, 4'b0000, 4'b0000};
      tab[12] = '{2'b01, 5'd0,  4'b1001, 4'b1000, 4'b0000};
      tab[13] = '{2'b01, 5'd0,  4'b0001, 4'b0000, 4'b0000};
      tab[14] = '{2'b01, 5'd0,  4'b1001, 4'b1000, 4'b0000};
      tab[15] = '{2'b01, 5'd0,  4'b0001, 4'b0000, 4'b0000};
      tab[16] = '{2'b01, 5'd0,  4'b1001, 4'b1000, 4'b0000};
      tab[17] = '{2'b11, 5'd0,  4'b0001, 4'b0000, 4'b0000};
      tab[18] = '{2'b11, 5'd0,  4'b1001, 4'b0000, 4'b0000};
      tab[19] = '{2'b11, 5'd0,  4'b0001, 4'b0000, 4'b0000};
      tab[20] = '{2'b11, 5'd0,  4'b1001, 4'b0000, 4'b0000};

      reset = 1'b1; in_v = '0; mode = 2'b00; holdoff = 5'd20; sb_en = 1'b1;
      tick(1);
      chk("reset_out", 32'(out_p1), 32'h0);
      chk("reset_missed", 32'(missed_p1), 32'h0);
      chk("reset_any", 32'(any_p1), 32'h0);
      tick(1);
      reset = 1'b0;

      for (int j = 0; j < 21; j++) begin
         mode = tab[j].mode; holdoff = tab[j].hold; in_v = tab[j].in;
         tick(1);
         chk($sformatf("tab%0d_out", j), 32'(out_p1), 32'(tab[j].exp_out));
         chk($sformatf("tab%0d_missed", j), 32'(missed_p1), 32'(tab[j].exp_miss));
      end

      // Simultaneous rising edges on every channel.
      do_reset();
      mode = 2'b00; holdoff = 5'd20; in_v = 4'b1111;
      tick(3);
      chk("simul_early", 32'(out_p1), 32'h0);
      tick(1);
      chk("simul_out", 32'(out_p1), 32'hf);
      chk("simul_any", 32'(any_p1), 32'h1);
      chk("simul_out_p3", 32'(out_p3), 32'hf);

      // Rise, fall, re-rise during holdoff: one pulse, one missed flag.
      do_reset();
      mode = 2'b00; holdoff = 5'd20;
      out_cnt = 0; out_at = -1; miss_cnt = 0; miss_at = -1;
      for (int k = 0; k < 30; k++) begin
         in_v[2] = (k < 4) ? 1'b1 : ((k < 9) ? 1'b0 : 1'b1);
         tick(1);
         if (out_p1[2]) begin out_cnt++; out_at = k; end
         if (missed_p1[2]) begin miss_cnt++; miss_at = k; end
      end
      chk("rerise_out_cnt", 32'(out_cnt), 32'd1);
      chk("rerise_out_at", 32'(out_at), 32'd3);
      chk("rerise_miss_cnt", 32'(miss_cnt), 32'd1);
      chk("rerise_miss_at", 32'(miss_at), 32'd12);

      // Both edges, PULSE_LEN=3, holdoff 5, toggles every 12 cycles.
      do_reset();
      mode = 2'b10; holdoff = 5'd5;
      out_cnt = 0; rises = 0; miss_cnt = 0; any_cnt = 0; prev = 0;
      for (int k = 0; k < 60; k++) begin
         in_v[1] = ((k / 12) % 2) == 1;
         tick(1);
         if (out_p3[1]) out_cnt++;
         if (out_p3[1] && !prev) rises++;
         prev = out_p3[1];
         if (any_p3) any_cnt++;
         if (missed_p3 != 4'b0) miss_cnt++;
      end
      chk("both_high_cycles", 32'(out_cnt), 32'd12);
      chk("both_pulses", 32'(rises), 32'd4);
      chk("both_any_cycles", 32'(any_cnt), 32'd12);
      chk("both_missed", 32'(miss_cnt), 32'd0);

      // Reset two cycles into a PULSE_LEN=4 pulse, then release with input high.
      do_reset();
      mode = 2'b00; holdoff = 5'd3; in_v = 4'b0001;
      tick(4);
      chk("rst_pulse_on", 32'(out_p4), 32'h1);
      tick(1);
      reset = 1'b1;
      tick(1);
      chk("rst_abort_out", 32'(out_p4), 32'h0);
      chk("rst_abort_any", 32'(any_p4), 32'h0);
      tick(1);
      reset = 1'b0;
      tick(3);
      chk("rel_early", 32'(out_p4), 32'h0);
      tick(1);
      chk("rel_pulse_0", 32'(out_p4), 32'h1);
      for (int k = 1; k < 4; k++) begin
         tick(1);
         chk($sformatf("rel_pulse_%0d", k), 32'(out_p4), 32'h1);
      end
      tick(1);
      chk("rel_pulse_end", 32'(out_p4), 32'h0);

      // Random traffic against the scoreboard model.
      do_reset();
      for (int k = 0; k < 400; k++) begin
         in_v = in_v ^ (4'($urandom) & 4'($urandom));
         holdoff = 5'($urandom_range(0, 6));
         if ($urandom_range(0, 15) == 0) mode = 2'($urandom_range(0, 3));
         tick(1);
      end

      sb_en = 1'b0;
      tick(2);
      $display("%0d/%0d checks passed", npass, nchk);
      $finish;
   end

endmodule

// File: doc/multi_edge_detect.md
# multi_edge_detect

Multi-channel, parametrised edge detector with per-channel pulse generation and holdoff. Each channel synchronises an asynchronous input, detects rising, falling or both edges, emits a fixed-length output pulse, then ignores that channel for a run-time-programmable holdoff period. Edges that arrive during pulse or holdoff are flagged rather than silently dropped. It sits between the raw comparator/trigger inputs and the delay-line capture logic.

## Interface

- CHANNELS, 4, number of independent input channels (≥1)
- SYNC_STAGES, 2, synchroniser flops per channel (0 = input used directly, already synchronous)
- PULSE_LEN, 1, output pulse length in cycles (≥1)
- HOLD_WIDTH, 5, width of holdoff count

- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- in  in  CHANNELS  channel inputs, asynchronous unless SYNC_STAGES=0
- mode  in  2  shared by all channels: 00 rising, 01 falling, 10 both, 11 disabled
- holdoff  in  HOLD_WIDTH  holdoff length in cycles, sampled per channel at detection
- out  out  CHANNELS  per-channel detection pulse, registered
- missed  out  CHANNELS  one-cycle flag: qualifying edge seen while channel busy
- any_out  out  1  OR of out, registered alongside out

## Operation

- Per channel: synchroniser chain → sample `s`; previous-sample register `p` loads `s` every cycle in every state, including ASSERT/HOLDOFF.
- Qualifying edge: rising = `s & ~p`; falling = `~s & p`; both = `s ^ p`; disabled = none.
- Per-channel FSM, states WAIT, ASSERT, HOLDOFF; one counter of width max(HOLD_WIDTH, clog2(PULSE_LEN+1)).
  - WAIT: on qualifying edge → ASSERT, counter ← 0, latch holdoff value `h`.
  - ASSERT: counter increments; when counter = PULSE_LEN−1 → HOLDOFF with counter ← 0, or → WAIT if `h` = 0.
  - HOLDOFF: counter increments; when counter = `h`−1 → WAIT.
- out[i] = (state == ASSERT), registered. any_out = OR of out.
- missed[i] pulses for one cycle when a qualifying edge occurs while state is ASSERT or HOLDOFF. No re-trigger: returning to WAIT never detects a stale edge, because `p` tracks continuously. A level still high on return to WAIT does not fire.
- mode = 11: every channel goes to WAIT on the next clock. out and missed are low from that cycle on. `p` keeps tracking.
- Mode changes while not disabled apply immediately to edge qualification. They do not alter an in-progress pulse or holdoff.
- Changing holdoff mid-holdoff has no effect on that channel; the latched `h` is used.
- Channels are fully independent. Simultaneous edges on several channels each fire in the same cycle.

## Timing

- Reset: all synchroniser flops, `p`, counters = 0; state = WAIT; out = 0, missed = 0, any_out = 0. All outputs are low the cycle after reset is sampled high.
- Reset mid-pulse or mid-holdoff aborts immediately; no pulse completion.
- After reset release, an input already high counts as a rising edge once it reaches `s`.
- Latency: an input change first sampled at clock edge t gives out high from edge t+SYNC_STAGES+1. With SYNC_STAGES = 0 this is t+1.
- out is high for exactly PULSE_LEN cycles. The earliest next detection is PULSE_LEN + `h` cycles after out first rose. An edge arriving exactly in the cycle the FSM returns to WAIT is detected.
- missed asserts SYNC_STAGES+1 cycles after the offending input change, matching out latency.

## Test plan

- CHANNELS=4, SYNC_STAGES=2, PULSE_LEN=1, holdoff=20, mode=00; ch0 rises at edge 10 → out[0] high only at edge 13. No other out. Input held high → no further pulse.
- mode=10, PULSE_LEN=3, holdoff=5; ch1 toggles every 12 cycles → out[1] pulses 3 cycles wide for each toggle, rising and falling. missed stays 0.
- mode=00, holdoff=20; ch2 rises, falls, and rises again 6 cycles after first out → exactly one out pulse; missed[2] high one cycle, 3 cycles after the second rise.
- Simultaneous rising edges on all 4 channels → out = 1111 in the same cycle; any_out high in that cycle.
- Reset asserted 2 cycles into a PULSE_LEN=4 pulse → out = 0 the next cycle. After release with input held high → one new pulse at release+SYNC_STAGES+1.
- holdoff=0, PULSE_LEN=1, mode=01 with ch3 falling every 2 cycles → every falling edge fires. Then switch mode=11 mid-pulse → out[3] low the next cycle, no further pulses.
